// File: rtl/ram_dq_burst_master_pkg.sv
// ram_dq_burst_master_pkg: shared widths, FSM state type and byte-enable selection
// for the RAM burst master and its read buffer.
package ram_dq_burst_master_pkg;
    localparam int RAM_ADDR_W      = 14;
    localparam int RAM_DATA_W      = 16;
    localparam int RAM_LEN_W       = 10;
    localparam int RAM_RDBUF_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    function automatic logic [1:0] be_sel(input logic [1:0] first_be, input logic [1:0] last_be,
                                          input logic is_first, input logic is_last);
        return (is_first && is_last) ? (first_be & last_be) :
               is_first ? first_be : is_last ? last_be : 2'b11;
    endfunction
endpackage

// File: rtl/ram_dq_rdbuf.sv
// ram_dq_rdbuf: DEPTH-entry synchronous FIFO holding RAM read words until the
// downstream consumer takes them.
module ram_dq_rdbuf import ram_dq_burst_master_pkg::*; #(
    parameter int  W     = RAM_DATA_W,
    parameter int  DEPTH = RAM_RDBUF_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = count_q == CW'(DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = do_push ? inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/ram_dq_burst_master.sv
// ram_dq_burst_master: sequences one write or read burst at a time onto a
// byte-enabled single-port RAM with 1-cycle registered read data.
module ram_dq_burst_master import ram_dq_burst_master_pkg::*; #(
    parameter int ADDR_W      = RAM_ADDR_W,
    parameter int DATA_W      = RAM_DATA_W,
    parameter int LEN_W       = RAM_LEN_W,
    parameter int RDBUF_DEPTH = RAM_RDBUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len_m1,
    input  logic [1:0]        req_first_be,
    input  logic [1:0]        req_last_be,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              ram_clock_en,
    output logic              ram_we,
    output logic [1:0]        ram_byte_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);
    localparam int CNT_W = LEN_W + 1;
    localparam int BCW   = $clog2(RDBUF_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ram_address_q, ram_address_d;
    logic [CNT_W-1:0]  iss_q, iss_d, rem_q, rem_d, req_cnt;
    logic [1:0]        first_be_q, first_be_d, last_be_q, last_be_d, ram_byte_en_q, ram_byte_en_d;
    logic              first_q, first_d, rd_pend_q, rd_pend_d;
    logic              req_ready_q, req_ready_d, wr_ready_q, wr_ready_d, done_q, done_d;
    logic              ram_clock_en_q, ram_clock_en_d, ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic [BCW-1:0]    inflight_q, inflight_d, buf_count;
    logic              accept, wr_hs, issue, pop, buf_full, buf_empty;

    assign req_cnt      = {1'b0, req_len_m1} + CNT_W'(1);
    assign accept       = req_valid && req_ready_q;
    assign wr_hs        = wr_valid && wr_ready_q;
    assign pop          = rd_valid && rd_ready;
    // Issued-but-uncaptured reads reserve buffer slots so a stalled consumer never overflows it.
    assign issue        = state_q == READ && iss_q != '0 && !buf_full &&
                          (int'(buf_count) + int'(inflight_q)) < RDBUF_DEPTH;
    assign rd_valid     = !buf_empty;
    assign rd_last      = rd_valid && rem_q == CNT_W'(1);
    assign req_ready    = req_ready_q;
    assign wr_ready     = wr_ready_q;
    assign done         = done_q;
    assign ram_clock_en = ram_clock_en_q;
    assign ram_we       = ram_we_q;
    assign ram_byte_en  = ram_byte_en_q;
    assign ram_address  = ram_address_q;
    assign ram_data     = ram_data_q;

    ram_dq_rdbuf #(.W(DATA_W), .DEPTH(RDBUF_DEPTH)) u_rdbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_q),
        .push_data (ram_q),
        .pop       (pop),
        .pop_data  (rd_data),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        iss_d          = iss_q;
        rem_d          = rem_q;
        first_be_d     = first_be_q;
        last_be_d      = last_be_q;
        first_d        = first_q;
        done_d         = 1'b0;
        ram_clock_en_d = 1'b0;
        ram_we_d       = 1'b0;
        ram_byte_en_d  = '0;
        ram_address_d  = '0;
        ram_data_d     = '0;
        rd_pend_d      = ram_clock_en_q && !ram_we_q;
        inflight_d     = inflight_q + BCW'(issue) - BCW'(rd_pend_q);
        if (accept) begin
            state_d    = req_write ? WRITE : READ;
            addr_d     = req_addr;
            iss_d      = req_cnt;
            rem_d      = req_cnt;
            first_be_d = req_first_be;
            last_be_d  = req_last_be;
            first_d    = 1'b1;
        end
        if (wr_hs) begin
            ram_clock_en_d = 1'b1;
            ram_we_d       = 1'b1;
            ram_byte_en_d  = be_sel(first_be_q, last_be_q, first_q, rem_q == CNT_W'(1));
            ram_address_d  = addr_q;
            ram_data_d     = wr_data;
            addr_d         = addr_q + ADDR_W'(1);
            rem_d          = rem_q - CNT_W'(1);
            first_d        = 1'b0;
        end
        if (issue) begin
            ram_clock_en_d = 1'b1;
            ram_byte_en_d  = 2'b11;
            ram_address_d  = addr_q;
            addr_d         = addr_q + ADDR_W'(1);
            iss_d          = iss_q - CNT_W'(1);
        end
        if (pop) rem_d = rem_q - CNT_W'(1);
        if ((wr_hs || pop) && rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
        req_ready_d = state_d == IDLE;
        wr_ready_d  = state_d == WRITE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            iss_q          <= '0;
            rem_q          <= '0;
            first_be_q     <= '0;
            last_be_q      <= '0;
            first_q        <= 1'b0;
            rd_pend_q      <= 1'b0;
            inflight_q     <= '0;
            req_ready_q    <= 1'b0;
            wr_ready_q     <= 1'b0;
            done_q         <= 1'b0;
            ram_clock_en_q <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_byte_en_q  <= '0;
            ram_address_q  <= '0;
            ram_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            iss_q          <= iss_d;
            rem_q          <= rem_d;
            first_be_q     <= first_be_d;
            last_be_q      <= last_be_d;
            first_q        <= first_d;
            rd_pend_q      <= rd_pend_d;
            inflight_q     <= inflight_d;
            req_ready_q    <= req_ready_d;
            wr_ready_q     <= wr_ready_d;
            done_q         <= done_d;
            ram_clock_en_q <= ram_clock_en_d;
            ram_we_q       <= ram_we_d;
            ram_byte_en_q  <= ram_byte_en_d;
            ram_address_q  <= ram_address_d;
            ram_data_q     <= ram_data_d;
        end
    end
endmodule

// File: tb/tb_ram_dq_burst_master.sv
// tb_ram_dq_burst_master: directed bench for the RAM burst master with a
// behavioural byte-enabled RAM on its port.
module tb_ram_dq_burst_master;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [13:0] req_addr;
    logic [9:0]  req_len_m1;
    logic [1:0]  req_first_be, req_last_be;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready, rd_last, done;
    logic [15:0] rd_data;
    logic        ram_clock_en, ram_we;
    logic [1:0]  ram_byte_en;
    logic [13:0] ram_address;
    logic [15:0] ram_data, ram_q;
    logic [15:0] mem [0:16383];
    logic [13:0] seen [8];
    logic [13:0] wrap_exp [4];
    logic [54:0] outs;
    int          checks = 0, fails = 0;

    always #5 clk = ~clk;

    ram_dq_burst_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len_m1   (req_len_m1),
        .req_first_be (req_first_be),
        .req_last_be  (req_last_be),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .done         (done),
        .ram_clock_en (ram_clock_en),
        .ram_we       (ram_we),
        .ram_byte_en  (ram_byte_en),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_q        (ram_q)
    );

    assign outs = {req_ready, wr_ready, rd_valid, rd_last, rd_data, done,
                   ram_clock_en, ram_we, ram_byte_en, ram_address, ram_data};

    always @(posedge clk)
        if (ram_clock_en) begin
            if (ram_we) begin
                if (ram_byte_en[0]) mem[ram_address][7:0] <= ram_data[7:0];
                if (ram_byte_en[1]) mem[ram_address][15:8] <= ram_data[15:8];
            end else ram_q <= mem[ram_address];
        end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic w, input logic [13:0] a, input logic [9:0] lm1,
                       input logic [1:0] fbe, input logic [1:0] lbe);
        req_valid = 1'b1;
        req_write = w;
        req_addr = a;
        req_len_m1 = lm1;
        req_first_be = fbe;
        req_last_be = lbe;
        check("req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wburst(input logic [13:0] a, input int n, input logic [1:0] fbe, input logic [1:0] lbe,
                          input logic [15:0] d0, input logic [15:0] step);
        logic [1:0]  be;
        logic [33:0] exp;
        cmd(1'b1, a, 10'(n - 1), fbe, lbe);
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                be = (n == 1) ? (fbe & lbe) : (i == 1) ? fbe : (i == n) ? lbe : 2'b11;
                exp = {1'b1, 1'b1, be, 14'(a + 14'(i - 1)), 16'(d0 + step * 16'(i - 1))};
                check("wr_beat", 64'({ram_we, ram_clock_en, ram_byte_en, ram_address, ram_data}), 64'(exp));
                if (i <= 8) seen[i - 1] = ram_address;
            end
            if (i < n) begin
                check("wr_ready", 64'(wr_ready), 64'(1));
                wr_valid = 1'b1;
                wr_data = 16'(d0 + step * 16'(i));
                @(posedge clk);
                @(negedge clk);
            end
        end
        check("wr_done", 64'(done), 64'(1));
        wr_valid = 1'b0;
    endtask

    task automatic rburst(input logic [13:0] a, input int n, input logic toggle, input int stop_at,
                          input logic [15:0] e0, input logic [15:0] step);
        int got = 0, issued = 0, k = 1, peak = 0;
        cmd(1'b0, a, 10'(n - 1), 2'b11, 2'b11);
        while (got < stop_at && k < 200) begin
            if (ram_clock_en && !ram_we) issued++;
            if (issued - got > peak) peak = issued - got;
            rd_ready = toggle ? k[0] : 1'b1;
            if (rd_valid && rd_ready) begin
                check("rd_data", 64'(rd_data), 64'(16'(e0 + step * 16'(got))));
                check("rd_last", 64'(rd_last), 64'(got == n - 1));
                if (!toggle) check("rd_time", 64'(k), 64'(got + 4));
                got++;
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        if (got < stop_at) check("rd_timeout", 64'(got), 64'(stop_at));
        if (stop_at == n) begin
            rd_ready = 1'b0;
            check("rd_done", 64'(done), 64'(1));
            check("rd_issued", 64'(issued), 64'(n));
            check("rd_peak_le4", 64'(peak <= 4), 64'(1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_len_m1 = '0;
        req_first_be = '0;
        req_last_be = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        rd_ready = 1'b0;
        wrap_exp = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        repeat (3) @(negedge clk);
        check("reset_outs", 64'(outs), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'(1));

        wburst(14'h0010, 4, 2'b11, 2'b11, 16'h1111, 16'h1111);
        @(negedge clk);
        check("done_one_cycle", 64'({done, ram_clock_en}), 64'(0));
        rburst(14'h0010, 4, 1'b0, 4, 16'h1111, 16'h1111);
        @(negedge clk);
        check("rd_idle", 64'({done, rd_valid, ram_clock_en}), 64'(0));

        wburst(14'h0020, 1, 2'b11, 2'b11, 16'h0000, 16'h0000);
        @(negedge clk);
        wburst(14'h0020, 1, 2'b10, 2'b11, 16'hABCD, 16'h0000);
        rburst(14'h0020, 1, 1'b0, 1, 16'hAB00, 16'h0000);
        @(negedge clk);

        wburst(14'h0100, 8, 2'b11, 2'b11, 16'h0111, 16'h0111);
        @(negedge clk);
        rburst(14'h0100, 8, 1'b1, 8, 16'h0111, 16'h0111);
        @(negedge clk);

        wburst(14'h3FFE, 4, 2'b01, 2'b10, 16'h0A0A, 16'h0101);
        for (int i = 0; i < 4; i++) check("wrap_addr", 64'(seen[i]), 64'(wrap_exp[i]));
        @(negedge clk);

        wburst(14'h0200, 8, 2'b11, 2'b11, 16'h1001, 16'h1001);
        @(negedge clk);
        rburst(14'h0200, 8, 1'b0, 2, 16'h1001, 16'h1001);
        rst_n = 1'b0;
        #1;
        check("midburst_reset_outs", 64'(outs), 64'(0));
        rd_ready = 1'b0;
        @(negedge clk);
        check("held_reset_outs", 64'(outs), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 64'({req_ready, rd_valid}), 64'(2));
        rburst(14'h0010, 4, 1'b0, 4, 16'h1111, 16'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/ram_dq_burst_master.md
# ram_dq_burst_master

Burst initiator for the single-port byte-enabled 16-bit RAM (14-bit address port, 1-cycle registered read data) used in the PCIe DMA test path. It accepts one burst command at a time (start address, length, direction, edge byte enables) and sequences it onto the RAM port. Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream with full backpressure. It sits between the DMA engine's command/data streams and the RAM.

## Interface
- ADDR_W, 14, RAM word address width
- DATA_W, 16, RAM data width (2 byte lanes)
- LEN_W, 10, burst length field width; length encoded as words-1 (1..1024)
- RDBUF_DEPTH, 4, read return buffer entries (minimum 3)

- Clock  in  1  single clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low; all state and outputs cleared while low
- ReqValid/ReqReady  in/out  1/1  command handshake
- ReqWrite  in  1  1 = write burst, 0 = read burst
- ReqAddr  in  ADDR_W  first word address
- ReqLenM1  in  LEN_W  words-1
- ReqFirstBE/ReqLastBE  in  2/2  byte enables for first/last word of a write
- WrValid/WrReady  in/out  1/1  write data handshake; WrData in DATA_W
- RdValid/RdReady  out/in  1/1  read data handshake; RdData out DATA_W; RdLast out 1 (final word)
- Done  out  1  one-cycle pulse at burst completion
- RamClockEn, RamWE  out  1/1  RAM enable / write strobe
- RamByteEn  out  2; RamAddress out ADDR_W; RamData out DATA_W
- RamQ  in  DATA_W  RAM read data, valid the cycle after RamAddress

## Operation
- FSM states: IDLE, WRITE, READ. ReqReady = (state==IDLE). Command accept latches address, remaining count, direction, BEs.
- IDLE -> WRITE / READ on accept. WRITE/READ -> IDLE in the cycle after the final handshake (last Wr handshake; RdLast Rd handshake); Done=1 in that cycle.
- WRITE: WrReady=1 in WRITE. Each Wr handshake at cycle t: RamWE=1, RamClockEn=1, RamAddress=current, RamData=WrData in t+1 (all RAM outputs registered). RamByteEn: first word ReqFirstBE, last word ReqLastBE, single-word burst ReqFirstBE & ReqLastBE, otherwise 2'b11. Address increments per word.
- READ: issue at cycle t when remaining issues >0 and (buffer count + in-flight) < RDBUF_DEPTH; RamAddress/RamClockEn=1 at t+1, RamWE=0, RamByteEn=2'b11; RamQ captured into ram_dq_rdbuf at end of t+2. In-flight counter covers the 2-cycle issue-to-capture window. Buffer must never overflow; no words lost or duplicated under any RdReady pattern.
- RdLast accompanies the final word only. RdData/RdValid come from buffer head.
- Address arithmetic modulo 2^ADDR_W (0x3FFF -> 0x0000). Count arithmetic LEN_W+1 bits; ReqLenM1=0x3FF gives 1024 words.
- Back-to-back: a new command may be accepted in the Done cycle; its first RAM access is at least one cycle after the final write of the previous burst, so read-after-write returns new data.
- Reset low (any time, including mid-burst): state IDLE, buffer and counters flushed, every output 0 (ReqReady=0 while in reset, 1 the first cycle after release). Partially written RAM contents are not restored.

## Timing
- Write: 1 word/cycle while WrValid held; RAM write commits end of t+1 for handshake at t.
- Read: command accepted at t0 -> first RdValid at t0+4; with RdReady held high, 1 word/cycle sustained, burst of N words ends at t0+3+N.
- Done: exactly one cycle, cycle after final handshake; never asserted in reset.
- RamClockEn=0 whenever no access is driven.

## Structure
- Shared package: state enum (IDLE/WRITE/READ), ADDR_W/DATA_W/LEN_W constants, BE select helper.
- One sub-module: ram_dq_rdbuf, synchronous RDBUF_DEPTH-entry FIFO (push, pop, count, full/empty), async active-low reset.

## Test plan
- Write addr 0x0010 len 4 data 0x1111/0x2222/0x3333/0x4444 BE 11/11 -> RamWE 4 consecutive cycles at 0x10..0x13, Done the cycle after 4th handshake.
- Read addr 0x0010 len 4, RdReady=1 -> RdData 0x1111..0x4444 on cycles t0+4..t0+7, RdLast on 0x4444, Done next cycle.
- Single-word write addr 0x20 data 0xABCD, FirstBE=10, LastBE=11 over prior 0x0000 -> RamByteEn=10; readback 0xAB00.
- Read len 8 with RdReady toggling 1/0 -> 8 distinct words in order, buffer count+in-flight never >4, no duplicates.
- Write addr 0x3FFE len 4 -> RamAddress 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Reset low after 2 read beats of a len-8 burst -> all outputs 0 immediately; after release ReqReady=1, new read returns correct data with no stale buffer words.
